// File: rtl/lfsr_pkg.sv
// Shared definitions for the lfsr_gen LFSR block: mode encodings and
// maximal-length default tap masks for widths 3..16.
package lfsr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_FIB  = 3'd1,
        MODE_GAL  = 3'd2,
        MODE_REV  = 3'd3,
        MODE_STEP = 3'd4,
        MODE_LOAD = 3'd5
    } lfsr_mode_e;

    localparam int unsigned LFSR_MIN_WIDTH = 3;
    localparam int unsigned LFSR_MAX_WIDTH = 16;

    // Masks have bit W-1 set; bit k is the tap on x^(k+1).
    function automatic logic [15:0] default_poly(input int unsigned width);
        logic [15:0] p;
        case (width)
            3:       p = 16'h0006;
            4:       p = 16'h000C;
            5:       p = 16'h0014;
            6:       p = 16'h0030;
            7:       p = 16'h0060;
            8:       p = 16'h00B8;
            9:       p = 16'h0110;
            10:      p = 16'h0240;
            11:      p = 16'h0500;
            12:      p = 16'h0E08;
            13:      p = 16'h1C80;
            14:      p = 16'h3802;
            15:      p = 16'h6000;
            16:      p = 16'hB400;
            default: p = 16'h0000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state function for lfsr_gen: Fibonacci forward,
// Galois and Fibonacci reverse stepping plus an all-zero flag.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned          WIDTH = 8,
    parameter logic [WIDTH-1:0]     POLY  = 8'hB8
) (
    input  logic [WIDTH-1:0] i_state,
    input  lfsr_mode_e       i_mode,
    output logic [WIDTH-1:0] o_next,
    output logic             o_zero
);

    logic w_fib_bit;
    logic w_rev_bit;

    assign w_fib_bit = ^(i_state & POLY);
    // Reverse recovers the bit shifted out by FIB; the MSB tap is the bit itself.
    assign w_rev_bit = i_state[0] ^ (^(i_state[WIDTH-1:1] & POLY[WIDTH-2:0]));
    assign o_zero    = (i_state == '0);

    always_comb begin
        o_next = i_state;
        case (i_mode)
            MODE_FIB, MODE_STEP: o_next = {i_state[WIDTH-2:0], w_fib_bit};
            MODE_GAL:            o_next = (i_state >> 1) ^ (i_state[0] ? POLY : '0);
            MODE_REV:            o_next = {w_rev_bit, i_state[WIDTH-1:1]};
            default:             o_next = i_state;
        endcase
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with single-step, seed load, lock-up recovery
// and wrap marker; LFSR_PERIOD_CNT_EN adds a measured-period output.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [2:0]       mod,
    input  logic             step,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] lfsr,
    output logic             bit_o,
    output logic             wrap,
    output logic             lockup
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [WIDTH-1:0] period
`endif
);

    lfsr_mode_e       w_mode;
    logic [WIDTH-1:0] w_next;
    logic             w_zero;
    logic             w_step_edge;
    logic             w_do_step;
    logic             w_do_load;
    logic [WIDTH-1:0] w_lfsr_d;
    logic [WIDTH-1:0] w_ref_d;
    logic             w_wrap_d;
    logic             w_lock_d;

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_ref_seed;
    logic             r_wrap;
    logic             r_lockup;
    logic             r_step_q;

    assign w_mode      = lfsr_mode_e'(mod);
    assign w_step_edge = step & ~r_step_q;

    lfsr_next #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_next (
        .i_state (r_lfsr),
        .i_mode  (w_mode),
        .o_next  (w_next),
        .o_zero  (w_zero)
    );

    always_comb begin
        w_do_step = 1'b0;
        w_do_load = 1'b0;
        if (ena) begin
            case (w_mode)
                MODE_FIB, MODE_GAL, MODE_REV: w_do_step = 1'b1;
                MODE_STEP:                    w_do_step = w_step_edge;
                MODE_LOAD:                    w_do_load = 1'b1;
                default:                      w_do_step = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_lfsr_d = r_lfsr;
        w_ref_d  = r_ref_seed;
        w_wrap_d = 1'b0;
        w_lock_d = 1'b0;
        if (w_do_load) begin
            if (seed == '0) begin
                w_lfsr_d = SEED;
                w_ref_d  = SEED;
                w_lock_d = 1'b1;
            end else begin
                w_lfsr_d = seed;
                w_ref_d  = seed;
            end
        end else if (w_do_step) begin
            // Recovery replaces the step entirely, so it never counts as a wrap.
            if (w_zero) begin
                w_lfsr_d = SEED;
                w_lock_d = 1'b1;
            end else begin
                w_lfsr_d = w_next;
                w_wrap_d = (w_next == r_ref_seed);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr     <= SEED;
            r_ref_seed <= SEED;
            r_wrap     <= 1'b0;
            r_lockup   <= 1'b0;
            r_step_q   <= 1'b0;
        end else begin
            r_lfsr     <= w_lfsr_d;
            r_ref_seed <= w_ref_d;
            r_wrap     <= w_wrap_d;
            r_lockup   <= w_lock_d;
            r_step_q   <= step;
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_period <= '0;
        end else if (w_do_load || w_lock_d) begin
            r_count <= '0;
        end else if (w_wrap_d) begin
            r_period <= r_count + 1'b1;
            r_count  <= '0;
        end else if (w_do_step) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign period = r_period;
`endif

    assign lfsr   = r_lfsr;
    assign bit_o  = r_lfsr[0];
    assign wrap   = r_wrap;
    assign lockup = r_lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen at WIDTH=4, POLY=4'hC, SEED=1; define
// LFSR_PERIOD_CNT_EN to also check the period output.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic [2:0] mod;
    logic       step;
    logic [3:0] seed;
    logic [3:0] lfsr;
    logic       bit_o;
    logic       wrap;
    logic       lockup;
`ifdef LFSR_PERIOD_CNT_EN
    logic [3:0] period;
`endif

    always #5 clk = ~clk;

    lfsr_gen #(
        .WIDTH (4),
        .POLY  (4'hC),
        .SEED  (4'h1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ena    (ena),
        .mod    (mod),
        .step   (step),
        .seed   (seed),
        .lfsr   (lfsr),
        .bit_o  (bit_o),
        .wrap   (wrap),
        .lockup (lockup)
`ifdef LFSR_PERIOD_CNT_EN
        ,
        .period (period)
`endif
    );

    typedef struct {
        int unsigned cyc;
        logic [3:0]  lfsr;
        logic        wrap;
        logic        lock;
        logic [3:0]  period;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  exp_period = 4'h0;

    // Hand-derived FIB orbit for x^4+x^3+1 starting at 0001.
    logic [3:0] ring [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                              4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic drive(input logic en, input logic [2:0] m, input logic st, input logic [3:0] sd,
                         input logic [3:0] e_lfsr, input logic e_wrap, input logic e_lock,
                         input string tag);
        exp_t e;
        ena  = en;
        mod  = m;
        step = st;
        seed = sd;
        e.cyc    = cyc + 1;
        e.lfsr   = e_lfsr;
        e.wrap   = e_wrap;
        e.lock   = e_lock;
        e.period = exp_period;
        e.tag    = tag;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            cmp({e.tag, ".lfsr"},   16'(lfsr),   16'(e.lfsr));
            cmp({e.tag, ".bit_o"},  16'(bit_o),  16'(e.lfsr[0]));
            cmp({e.tag, ".wrap"},   16'(wrap),   16'(e.wrap));
            cmp({e.tag, ".lockup"}, 16'(lockup), 16'(e.lock));
`ifdef LFSR_PERIOD_CNT_EN
            cmp({e.tag, ".period"}, 16'(period), 16'(e.period));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ena   = 1'b0;
        mod   = 3'd0;
        step  = 1'b0;
        seed  = 4'h0;
        repeat (2) @(posedge clk);
        #2;
        drive(1, 3'd1, 0, 4'h0, 4'h1, 0, 0, "reset");
        reset = 1'b0;

        for (int k = 1; k <= 15; k++) begin
            if (k == 15) exp_period = 4'd15;
            drive(1, 3'd1, 0, 4'h0, ring[k % 15], (k == 15), 0, "fib");
        end

        drive(1, 3'd2, 0, 4'h0, 4'hC, 0, 0, "gal1");
        drive(1, 3'd2, 0, 4'h0, 4'h6, 0, 0, "gal2");
        drive(1, 3'd2, 0, 4'h0, 4'h3, 0, 0, "gal3");
        drive(1, 3'd2, 0, 4'h0, 4'hD, 0, 0, "gal4");

        drive(1, 3'd5, 0, 4'h3, 4'h3, 0, 0, "load3");
        drive(1, 3'd3, 0, 4'h0, 4'h9, 0, 0, "rev1");
        drive(1, 3'd3, 0, 4'h0, 4'h4, 0, 0, "rev2");
        drive(1, 3'd3, 0, 4'h0, 4'h2, 0, 0, "rev3");
        drive(1, 3'd1, 0, 4'h0, 4'h4, 0, 0, "fwd1");
        drive(1, 3'd1, 0, 4'h0, 4'h9, 0, 0, "fwd2");
        exp_period = 4'd6;
        drive(1, 3'd1, 0, 4'h0, 4'h3, 1, 0, "fwd3");
        drive(1, 3'd0, 0, 4'h0, 4'h3, 0, 0, "hold");
        drive(1, 3'd6, 0, 4'h0, 4'h3, 0, 0, "rsvd6");

        drive(1, 3'd5, 0, 4'h0, 4'h1, 0, 1, "load0");
        drive(1, 3'd0, 0, 4'h0, 4'h1, 0, 0, "lockend");
        drive(1, 3'd5, 0, 4'h6, 4'h6, 0, 0, "load6");
        for (int k = 1; k <= 15; k++) begin
            if (k == 15) exp_period = 4'd15;
            drive(1, 3'd1, 0, 4'h0, ring[(5 + k) % 15], (k == 15), 0, "fib6");
        end

        drive(1, 3'd5, 0, 4'h1, 4'h1, 0, 0, "load1");
        drive(1, 3'd4, 0, 4'h0, 4'h1, 0, 0, "steplow");
        drive(1, 3'd4, 1, 4'h0, 4'h2, 0, 0, "stepedge");
        for (int k = 0; k < 4; k++) drive(1, 3'd4, 1, 4'h0, 4'h2, 0, 0, "stephigh");
        drive(1, 3'd4, 0, 4'h0, 4'h2, 0, 0, "stepfall");
        drive(0, 3'd4, 1, 4'h0, 4'h2, 0, 0, "ena0edge");
        drive(1, 3'd4, 1, 4'h0, 4'h2, 0, 0, "stale");
        drive(0, 3'd5, 0, 4'h0, 4'h2, 0, 0, "ena0load");
        drive(1, 3'd4, 1, 4'h0, 4'h4, 0, 0, "step2");

        drive(1, 3'd1, 0, 4'h0, 4'h9, 0, 0, "prereset");
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        cmp("async.lfsr",   16'(lfsr),   16'h1);
        cmp("async.wrap",   16'(wrap),   16'h0);
        cmp("async.lockup", 16'(lockup), 16'h0);
`ifdef LFSR_PERIOD_CNT_EN
        cmp("async.period", 16'(period), 16'h0);
`endif
        exp_period = 4'd0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive(1, 3'd1, 0, 4'h0, 4'h2, 0, 0, "resume1");
        drive(1, 3'd1, 0, 4'h0, 4'h4, 0, 0, "resume2");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
